// File: rtl/out_tx.sv
// -----------------------------------------------------------------------------
// out_tx : output-side UART transmitter for the 16-bit pipelined core.
//
// Words written by the core (out_en/out_dat) go into a circular FIFO. Each
// word is sent as two UART frames, high byte first. The core cannot be stalled.
// A word that arrives while the FIFO is full is dropped, and the sticky
// overflow flag is set.
//
// Parameters
//   DEPTH         FIFO depth in 16-bit words (power of two, >= 2)
//   CLKS_PER_BIT  clock cycles per UART bit (>= 2)
//
// Optional feature macro: OUT_TX_PARITY_EN
//   When it is defined, an even-parity bit (XOR of the data byte) follows data
//   bit 7. Each frame is then 11 bits long. When it is undefined, frames are
//   8N1.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-low reset
//   out_en     in   push strobe (one word per cycle)
//   out_dat    in   word to transmit, sampled when out_en=1
//   is_halt    in   core halted indicator (only qualifies halt_done)
//   txd        out  registered UART line, idles high
//   busy       out  serializer not in IDLE
//   count      out  FIFO occupancy 0..DEPTH
//   overflow   out  sticky, a push was dropped
//   drained    out  FIFO empty and serializer idle
//   halt_done  out  is_halt && drained (combinational)
// -----------------------------------------------------------------------------
module out_tx #(
   parameter int DEPTH        = 16,
   parameter int CLKS_PER_BIT = 434
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     out_en,
   input  logic [15:0]              out_dat,
   input  logic                     is_halt,
   output logic                     txd,
   output logic                     busy,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   output logic                     drained,
   output logic                     halt_done
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] FULL      = CW'(DEPTH);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
`ifdef OUT_TX_PARITY_EN
      S_PARITY,
`endif
      S_STOP
   } state_t;

   // FIFO storage and pointers
   logic [15:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q, count_d;
   logic          ovf_q;

   // Serializer state
   state_t        state_q, state_d;
   logic [7:0]    shift_q, shift_d;
   logic [2:0]    bit_q, bit_d;
   logic [BW-1:0] baud_q, baud_d;
   logic          hi_q, hi_d;
   logic [15:0]   word_q;
   logic          txd_q, txd_d;

   logic          pop, push, baud_end;
   logic [7:0]    cur_byte;

   // Serializer next state. txd_d is derived from the next state, so the
   // registered line changes on the same edge as the state.
   always_comb begin
      state_d  = state_q;
      shift_d  = shift_q;
      bit_d    = bit_q;
      baud_d   = baud_q;
      hi_d     = hi_q;
      pop      = 1'b0;
      baud_end = (baud_q == BAUD_LAST);
      cur_byte = hi_q ? word_q[15:8] : word_q[7:0];

      if (state_q != S_IDLE) begin
         baud_d = baud_end ? '0 : baud_q + BW'(1);
      end

      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               hi_d    = 1'b1;
               baud_d  = '0;
               state_d = S_START;
            end
         end
         S_START: begin
            if (baud_end) begin
               shift_d = cur_byte;
               bit_d   = 3'd0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            if (baud_end) begin
               if (bit_q == 3'd7) begin
`ifdef OUT_TX_PARITY_EN
                  state_d = S_PARITY;
`else
                  state_d = S_STOP;
`endif
               end else begin
                  shift_d = shift_q >> 1;
                  bit_d   = bit_q + 3'd1;
               end
            end
         end
`ifdef OUT_TX_PARITY_EN
         S_PARITY: begin
            if (baud_end) begin
               state_d = S_STOP;
            end
         end
`endif
         S_STOP: begin
            if (baud_end) begin
               if (hi_q) begin
                  hi_d    = 1'b0;
                  state_d = S_START;
               end else if (count_q != '0) begin
                  // Chain straight into the next word with no idle cycle
                  pop     = 1'b1;
                  hi_d    = 1'b1;
                  state_d = S_START;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase

      txd_d = 1'b1;
      case (state_d)
         S_START:  txd_d = 1'b0;
         S_DATA:   txd_d = shift_d[0];
`ifdef OUT_TX_PARITY_EN
         // hi_q is unchanged on entry to PARITY, so cur_byte is the byte just sent
         S_PARITY: txd_d = ^cur_byte;
`endif
         default:  txd_d = 1'b1;
      endcase
   end

   // A pop in the same cycle frees a slot, so a push into a full FIFO is still accepted
   assign push = out_en && ((count_q != FULL) || pop);

   always_comb begin
      case ({push, pop})
         2'b10:   count_d = count_q + CW'(1);
         2'b01:   count_d = count_q - CW'(1);
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         shift_q  <= '0;
         bit_q    <= '0;
         baud_q   <= '0;
         hi_q     <= 1'b0;
         txd_q    <= 1'b1;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         shift_q <= shift_d;
         bit_q   <= bit_d;
         baud_q  <= baud_d;
         hi_q    <= hi_d;
         txd_q   <= txd_d;
         count_q <= count_d;
         ovf_q   <= ovf_q | (out_en & ~push);
         if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      end
   end

   // RAM array with registered read. word_q is the output register, and it
   // loads on pop.
   always_ff @(posedge clk) begin
      if (push) mem_q[wr_ptr_q] <= out_dat;
      if (pop)  word_q <= mem_q[rd_ptr_q];
   end

   assign txd       = txd_q;
   assign busy      = (state_q != S_IDLE);
   assign count     = count_q;
   assign overflow  = ovf_q;
   assign drained   = (count_q == '0) && (state_q == S_IDLE);
   assign halt_done = is_halt && drained;

endmodule

// File: tb/tb_out_tx.sv
// -----------------------------------------------------------------------------
// Testbench for out_tx, using DEPTH=16 and CLKS_PER_BIT=4.
// A UART receiver samples each bit slot of txd at mid-bit and rebuilds words.
// It pops the expected word from the scoreboard queue and compares.
// -----------------------------------------------------------------------------
module tb_out_tx;

   localparam int DEPTH = 16;
   localparam int CPB   = 4;
`ifdef OUT_TX_PARITY_EN
   localparam int SLOTS = 22;
`else
   localparam int SLOTS = 20;
`endif
   localparam int WORD_CYC = SLOTS * CPB;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        out_en = 1'b0;
   logic [15:0] out_dat = '0;
   logic        is_halt = 1'b0;
   logic        txd, busy, overflow, drained, halt_done;
   logic [4:0]  count;

   out_tx #(.DEPTH(DEPTH), .CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .reset(reset), .out_en(out_en), .out_dat(out_dat),
      .is_halt(is_halt), .txd(txd), .busy(busy), .count(count),
      .overflow(overflow), .drained(drained), .halt_done(halt_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   int last_rst_cyc = -1;
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (!reset) last_rst_cyc <= cyc + 1;
   end

   int errors = 0;
   int checks = 0;

   logic [15:0]      exp_q[$];
   int               start_q[$];
   int               words_rx = 0;
   logic [SLOTS-1:0] last_bits = '0;
   bit               mon_busy = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Expected line bits for one word, with slot 0 first
   function automatic logic [SLOTS-1:0] frame_bits(input logic [15:0] w);
      logic [SLOTS-1:0] v;
      logic [7:0]       by;
      int               p;
      v = '0;
      p = 0;
      for (int h = 0; h < 2; h++) begin
         by = (h == 0) ? w[15:8] : w[7:0];
         v[p] = 1'b0; p = p + 1;
         for (int i = 0; i < 8; i++) begin
            v[p] = by[i]; p = p + 1;
         end
`ifdef OUT_TX_PARITY_EN
         v[p] = ^by; p = p + 1;
`endif
         v[p] = 1'b1; p = p + 1;
      end
      return v;
   endfunction

   // Line monitor
   initial begin : monitor
      logic [SLOTS-1:0] bits;
      int               w_start;
      logic [15:0]      w;
      forever begin
         @(negedge clk);
         while (txd === 1'b0 && reset === 1'b1) begin
            mon_busy = 1'b1;
            w_start  = cyc;
            for (int b = 0; b < SLOTS; b++) begin
               repeat ((b == 0) ? 2 : CPB) @(negedge clk);
               bits[b] = txd;
            end
            repeat (2) @(negedge clk);
            // A frame cut short by reset is not a transmitted word
            if (last_rst_cyc < w_start) begin
               words_rx++;
               start_q.push_back(w_start);
               last_bits = bits;
               chk("sb_word_expected", (exp_q.size() != 0), 1);
               if (exp_q.size() != 0) begin
                  w = exp_q.pop_front();
                  chk($sformatf("line_word_%04h", w), bits, frame_bits(w));
                  $display("rx word: expected %04h line %b at cycle %0d", w, bits, w_start);
               end
            end
            mon_busy = 1'b0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_drain(input int max);
      int n;
      n = 0;
      while (!(drained === 1'b1 && !mon_busy && exp_q.size() == 0) && n < max) begin
         tick();
         n++;
      end
      chk("drain_within_budget", (n < max), 1);
   endtask

   task automatic do_reset();
      reset = 1'b0;
      tick();
      reset = 1'b1;
      exp_q.delete();
   endtask

   typedef struct {
      bit          en;
      logic [15:0] dat;
      logic [4:0]  exp_count;
      bit          exp_ovf;
      bit          accept;
   } vec_t;

   vec_t vec[18];

   initial begin : main
      int t0;
      int n_rx;

      for (int i = 0; i < 18; i++) begin
         vec[i].en        = 1'b1;
         vec[i].dat       = 16'(i);
         vec[i].exp_count = (i == 0) ? 5'd1 : ((i > 16) ? 5'd16 : 5'(i));
         vec[i].exp_ovf   = (i == 17);
         vec[i].accept    = (i < 17);
      end

      // ---- reset held with pushes active
      reset = 1'b0; out_en = 1'b1; out_dat = 16'hFFFF;
      repeat (3) tick();
      chk("rst_txd", txd, 1);
      chk("rst_count", count, 0);
      chk("rst_busy", busy, 0);
      chk("rst_overflow", overflow, 0);
      chk("rst_drained", drained, 1);
      reset = 1'b1; out_en = 1'b0;
      repeat (60) tick();
      chk("rst_nothing_sent", words_rx, 0);
      chk("rst_txd_idle", txd, 1);

      // ---- single word 0x4841
      start_q.delete();
      out_en = 1'b1; out_dat = 16'h4841; exp_q.push_back(16'h4841);
      tick();
      t0 = cyc; out_en = 1'b0;
      chk("single_count_after_push", count, 1);
      chk("single_drained_after_push", drained, 0);
      tick();
      chk("single_txd_falls", txd, 0);
      chk("single_busy", busy, 1);
      chk("single_count_after_pop", count, 0);
      while (cyc < t0 + WORD_CYC) tick();
      chk("single_drained_before_end", drained, 0);
      is_halt = 1'b1;
      chk("single_halt_done_busy", halt_done, 0);
      tick();
      chk("single_drained_at_end", drained, 1);
      chk("single_halt_done", halt_done, 1);
      chk("single_txd_idle", txd, 1);
      wait_drain(200);
      is_halt = 1'b0;
      chk("single_first_bit_latency", start_q[0] - t0, 1);
`ifndef OUT_TX_PARITY_EN
      chk("single_line_literal", last_bits, 20'b1010_0000_1010_1001_0000);
`endif

      // ---- parity word 0x0301 (parity bits checked by the line model)
      out_en = 1'b1; out_dat = 16'h0301; exp_q.push_back(16'h0301);
      tick();
      out_en = 1'b0;
      wait_drain(WORD_CYC + 50);

      // ---- overflow: 18 consecutive pushes from the table
      start_q.delete();
      for (int i = 0; i < 18; i++) begin
         out_en  = vec[i].en;
         out_dat = vec[i].dat;
         if (vec[i].accept) exp_q.push_back(vec[i].dat);
         tick();
         chk($sformatf("ovf_count_%0d", i), count, vec[i].exp_count);
         chk($sformatf("ovf_flag_%0d", i), overflow, vec[i].exp_ovf);
      end
      out_en = 1'b0;
      wait_drain(17 * WORD_CYC + 200);
      chk("ovf_sticky", overflow, 1);
      chk("ovf_words_on_line", start_q.size(), 17);
      for (int k = 1; k < start_q.size(); k++)
         chk($sformatf("ovf_no_gap_%0d", k), start_q[k] - start_q[k-1], WORD_CYC);
      do_reset();
      chk("ovf_cleared_by_reset", overflow, 0);

      // ---- full FIFO with push on the same cycle as the STOP->START pop
      out_en = 1'b1; out_dat = 16'h1111; exp_q.push_back(16'h1111);
      tick();
      t0 = cyc; out_en = 1'b0;
      tick();
      for (int i = 0; i < 16; i++) begin
         out_en = 1'b1; out_dat = 16'h2000 + 16'(i); exp_q.push_back(out_dat);
         tick();
      end
      out_en = 1'b0;
      chk("full_count_16", count, 16);
      while (cyc < t0 + WORD_CYC) tick();
      chk("full_count_before_pop", count, 16);
      out_en = 1'b1; out_dat = 16'hBEEF; exp_q.push_back(16'hBEEF);
      tick();
      out_en = 1'b0;
      chk("full_simul_count", count, 16);
      chk("full_simul_overflow", overflow, 0);
      chk("full_next_start", txd, 0);
      wait_drain(18 * WORD_CYC + 200);
      chk("full_overflow_end", overflow, 0);

      // ---- reset in the middle of the high byte of 0xA5A5
      out_en = 1'b1; out_dat = 16'hA5A5; exp_q.push_back(16'hA5A5);
      tick();
      t0 = cyc; out_en = 1'b0;
      while (cyc < t0 + 10) tick();
      chk("midrst_busy_before", busy, 1);
      do_reset();
      chk("midrst_txd", txd, 1);
      chk("midrst_count", count, 0);
      chk("midrst_busy", busy, 0);
      n_rx = words_rx;
      repeat (200) tick();
      chk("midrst_no_frames", words_rx, n_rx);
      chk("midrst_txd_idle", txd, 1);
      chk("midrst_drained", drained, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin : watchdog
      #1000000;
      $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule

// File: doc/out_tx.md
# out_tx

Output-side UART transmitter for the 16-bit pipelined core. It takes the core's output-port write strobe and data (`out_en`/`out_dat`) and buffers the words in a FIFO. Each word is then serialised onto a single UART line as two 8N1 frames, high byte first. The core has no backpressure on its output port, so this block absorbs bursts, drops words on overflow and reports drain status for halt handling.

## Interface
- `DEPTH`, 16: FIFO depth in 16-bit words; power of two, at least 2.
- `CLKS_PER_BIT`, 434: clock cycles per UART bit (50 MHz / 115200); at least 2.

- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-low reset.
- `out_en` in 1: push strobe from core; one word per cycle while high.
- `out_dat` in 16: word to transmit; sampled when `out_en`=1.
- `is_halt` in 1: core halted indicator.
- `txd` out 1: UART serial line; idles high.
- `busy` out 1: serializer not in IDLE.
- `count` out $clog2(DEPTH)+1: FIFO occupancy, 0..DEPTH.
- `overflow` out 1: sticky; set when a push is dropped.
- `drained` out 1: FIFO empty and serializer IDLE.
- `halt_done` out 1: `is_halt` && `drained`; combinational.

## Operation
- FIFO:
  - Circular buffer with read/write pointers of width $clog2(DEPTH); pointers wrap modulo DEPTH.
  - `count` is a separate registered counter.
- Push:
  - `out_en`=1 and (`count`<DEPTH or a pop occurs in the same cycle): word written, write pointer advances.
  - Otherwise the word is dropped and `overflow` is set to 1 until reset.
- Pop: happens whenever the serializer loads a new word.
- Simultaneous push and pop: `count` is unchanged. This holds at full (push accepted) and at empty when a pop is not possible; a pop never happens while `count`=0.
- Serializer FSM, states IDLE, START, DATA, STOP. Registers: shift register (8 bits), bit counter (0..7), baud counter (0..CLKS_PER_BIT-1), byte select (HI/LO), latched 16-bit word.
  - IDLE:
    - `count`>0: pop, latch the word, select HI, go to START.
    - Otherwise stay in IDLE with `txd`=1.
  - START: `txd`=0 for CLKS_PER_BIT cycles, then go to DATA with the shift register loaded from the selected byte.
  - DATA: `txd` = shift[0] (LSB first), one bit per CLKS_PER_BIT cycles; after bit 7, go to STOP.
  - STOP: `txd`=1 for CLKS_PER_BIT cycles, then:
    - If HI was selected: select LO and go to START.
    - If LO was selected and `count`>0: pop and go straight to START with HI. No extra idle cycle.
    - Otherwise go to IDLE.
- `is_halt` does not gate pushes. It only qualifies `halt_done`.

## Timing
- Reset (`reset`=0 at an edge):
  - Next-state outputs: `txd`=1, `busy`=0, `count`=0, `overflow`=0, `drained`=1.
  - Pointers and counters are cleared and any frame in progress is aborted immediately.
- `txd` is registered and glitch-free.
- Word pushed at edge N into an empty, idle block:
  - Pop at edge N+1; `txd` falls at edge N+1.
  - Line returns to idle at edge N+1+20·CLKS_PER_BIT.
- Each word occupies exactly 20·CLKS_PER_BIT cycles on the line (2 × 10 bits).
- `count` reflects pushes and pops of edge N from edge N onward.

## Configuration
- `OUT_TX_PARITY_EN` defined:
  - An even-parity bit is inserted after data bit 7 via a PARITY state, lasting CLKS_PER_BIT cycles.
  - Parity bit = XOR of the 8 data bits.
  - Frame is 11 bits; one word takes 22·CLKS_PER_BIT cycles.
- `OUT_TX_PARITY_EN` undefined: 8N1 only; no PARITY state exists.

## Test plan
All scenarios use CLKS_PER_BIT=4 and DEPTH=16.
- Reset:
  - Hold `reset`=0 for 3 cycles with `out_en`=1 and `out_dat`=0xFFFF.
  - Required: `txd`=1, `count`=0, `busy`=0, `overflow`=0, `drained`=1, and nothing is transmitted after release.
- Single word:
  - Push 0x4841 at edge N.
  - Required `txd` from N+1, 4 cycles per bit: 0, 0,0,0,1,0,0,1,0, 1, 0, 1,0,0,0,0,0,1,0, 1.
  - Then idle high; `drained`=1 at N+81.
- Overflow:
  - Push 0x0000..0x0011 on 18 consecutive cycles.
  - Required: 0x0011 dropped, `overflow`=1 and stays 1, `count` peaks at 16.
  - Line carries 0x0000..0x0010 in order, back-to-back with no gaps.
- Full with simultaneous pop:
  - Fill to 16 while a word is in flight, then push 0xBEEF on the same cycle the STOP→START pop happens.
  - Required: accepted, `count` stays 16, `overflow` stays 0.
- Reset mid-frame:
  - Assert `reset` during DATA of 0xA5A5's high byte.
  - Required: `txd`=1 after the next edge, `count`=0, no further frames.
- Parity (`OUT_TX_PARITY_EN` defined):
  - Push 0x0301.
  - Required: parity bit 0 after byte 0x03 and 1 after byte 0x01.
  - Total 88 cycles; `halt_done`=1 once `is_halt`=1 and the line is idle.
